// File: rtl/encoder_83.sv
// encoder_83: registered 8-to-3 request encoder with sticky pending, overrun flags
// and a valid/ready output; code c corresponds to request bit 7-c.
module encoder_83 #(
    parameter bit EDGE = 1'b1,
    parameter bit RR = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] out_code,
    output logic [7:0] out_onehot,
    output logic [7:0] pending,
    output logic [7:0] overrun,
    input  logic       ovr_clr
);
    typedef enum logic {IDLE, PRESENT} state_t;
    state_t state, state_n;
    logic [7:0] req_d, ev, clr;
    logic [2:0] last, base, idx, sel;
    logic found, load, take;

    assign ev = EDGE ? req & ~req_d : req;
    assign take = state == PRESENT && out_ready;
    assign load = state == IDLE && |pending;
    // the presented one-hot is exactly the pending bit being retired
    assign clr = take ? out_onehot : 8'h00;
    assign out_valid = state == PRESENT;
    assign base = RR ? last + 3'd1 : 3'd0;

    always_comb begin
        sel = 3'd0;
        found = 1'b0;
        idx = 3'd0;
        for (int k = 0; k < 8; k++) begin
            idx = base + 3'(k);
            if (!found && pending[3'd7 - idx]) begin
                sel = idx;
                found = 1'b1;
            end
        end
    end

    always_comb state_n = load ? PRESENT : take ? IDLE : state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            req_d <= 8'h00;
            pending <= 8'h00;
            overrun <= 8'h00;
            out_code <= 3'b000;
            out_onehot <= 8'h00;
            last <= 3'b111;
        end else begin
            state <= state_n;
            req_d <= req;
            pending <= (pending & ~clr) | ev;
            overrun <= (ovr_clr ? 8'h00 : overrun) | (ev & pending & ~clr);
            if (load) begin
                out_code <= sel;
                out_onehot <= 8'h80 >> sel;
            end else if (take) begin
                out_onehot <= 8'h00;
            end
            if (take) last <= out_code;
        end
    end
endmodule

// File: doc/encoder_83.md
# encoder_83

Registered 8-to-3 request encoder: the inverse of the existing 3-to-8 one-hot decoder. It captures up to eight independent request lines into a sticky pending register and presents them one at a time as a 3-bit code with a valid/ready handshake. The codes use the same mapping as the decoder: code 3'b000 is request bit 7 and code 3'b111 is request bit 0, so `out_code` feeds the decoder directly to regenerate a one-hot grant. The block sits between raw event/IRQ sources on the board and a consumer that wants a single indexed stream.

## Interface
- `EDGE`, default 1: 1 = a request is a rising edge of `req[i]`; 0 = a request is a high level of `req[i]` each cycle.
- `RR`, default 0: 0 = fixed priority, lowest code (bit 7) wins; 1 = round-robin starting from the code after the last one granted.
- `clk`, input, 1: the single clock; all state changes on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `req`, input, 8: request lines, synchronous to `clk`.
- `out_valid`, output, 1: `out_code` holds a pending request.
- `out_ready`, input, 1: consumer accepts `out_code` on a cycle with `out_valid`=1.
- `out_code`, output, 3: encoded request; bit i maps to code 7-i.
- `out_onehot`, output, 8: registered one-hot equal to 8'b10000000 >> `out_code` while valid; 0 otherwise.
- `pending`, output, 8: sticky pending register, bit i maps to `req[i]`.
- `overrun`, output, 8: sticky flag per bit; a new request arrived while that bit was already pending.
- `ovr_clr`, input, 1: one-cycle pulse that clears `overrun`.

## Operation
- Event detection:
  - `EDGE`=1: `ev = req & ~req_d`, where `req_d` is registered `req` and resets to 8'h00. A line held high through reset release produces one event in the first cycle.
  - `EDGE`=0: `ev = req`.
- Pending update: `pending <= (pending & ~clr) | ev`.
  - `clr` is the one-hot of the accepted code on a handshake cycle, 0 otherwise.
  - If a set and a clear hit the same bit in the same cycle, the set wins. The bit stays pending and no overrun is recorded.
- Overrun:
  - `overrun[i]` sets when `ev[i]`=1 and `pending[i]`=1 and bit i is not being cleared that cycle.
  - `ovr_clr` clears all bits. If `ovr_clr` and a new overrun occur in the same cycle, the new overrun wins.
  - `EDGE`=0 with a held level therefore sets overrun. This is intended.
- The FSM has two states, IDLE and PRESENT.
  - IDLE: if `pending`≠0, select a code, register `out_code`/`out_onehot`, set `out_valid`, go to PRESENT. Otherwise stay in IDLE with `out_valid`=0.
  - PRESENT: `out_code` and `out_onehot` are held stable. On `out_ready`=1, clear that pending bit, drop `out_valid`, and return to IDLE. Otherwise stay in PRESENT.
- Selection:
  - `RR`=0: smallest code with a pending bit.
  - `RR`=1: first pending code scanning upward from (`last`+1) mod 8, wrapping 7→0. `last` resets to 3'b111, so the first scan starts at code 0, and it updates on each handshake.
- A request arriving during PRESENT does not change the presented code, even if it has higher priority.

## Timing
- Reset values: `out_valid`=0, `out_code`=3'b000, `out_onehot`=8'h00, `pending`=8'h00, `overrun`=8'h00, FSM in IDLE, `req_d`=8'h00, `last`=3'b111.
- Latency:
  - An event sampled at edge k sets `pending` at edge k.
  - `out_valid` rises after edge k+1.
  - This holds for an idle block.
- Handshake:
  - Transfer occurs at an edge where `out_valid` and `out_ready` are both 1.
  - `out_valid` is 0 for at least one cycle after every transfer, so peak throughput is one code per 2 cycles.
  - `out_ready` is ignored while `out_valid`=0.
- Reset asserted mid-PRESENT returns all outputs to reset values immediately (asynchronously). The pending request is lost.

## Test plan
- Reset, then `req`=8'h00 for 10 cycles → `out_valid`=0, `pending`=0, `overrun`=0 throughout.
- `EDGE`=1, `RR`=0: pulse `req`=8'b00100100 for one cycle, `out_ready`=1.
  - Expected: code 2 (`out_onehot` 8'h20) valid 2 cycles after the pulse, then code 5 (8'h04) two cycles later.
  - `pending` is 0 after the second transfer.
- Hold `out_ready`=0 with code 6 presented, then pulse `req[7]`.
  - Expected: `out_code` stays 6 until accepted; code 0 follows on the next presentation.
- `RR`=1, `req` held at 8'hFF with `EDGE`=0, `out_ready`=1.
  - Expected: codes 0,1,…,7,0 in order.
  - `overrun` becomes 8'hFF.
  - An `ovr_clr` pulse with `req`=0 returns `overrun` to 0.
- `EDGE`=1: pulse `req[3]`, then pulse `req[3]` again while code 4 is still pending and unaccepted.
  - Expected: `overrun`=8'h08.
  - Pulse `req[3]` on the exact accept edge of code 4. Expected: bit stays pending, no overrun, code 4 is presented again.
- Assert `rst` asynchronously while `out_valid`=1.
  - Expected: `out_valid`, `pending`, and `overrun` go to 0 before the next clock edge.
  - After release with `req`=8'h01 held (`EDGE`=1): code 7 is presented 2 cycles later.
